rob_retire: RTL and testbench

Retire stage: the consumer end of the ROB head interface. Each cycle it reads up to N oldest ROB entries and tracks completion via CDB broadcasts. It decides in order how many entries commit and drives num_retiring back to the ROB. It also frees old physical registers, updates the architectural map, and sequences mispredict flush and halt.

---
 rtl/rob_retire_pkg.sv | 42 ++++
 rtl/retire_complete_list.sv | 43 ++++
 rtl/rob_retire.sv | 127 ++++++++++++
 tb/tb_rob_retire.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_pkg.sv
// Shared definitions for the retire stage.
//   - Machine sizing: N (retire width), ROB_SZ, PHYS_REG_SZ and derived widths.
//   - rob_packet_t : the ROB head entry fields the retire stage consumes.
//   - amt_packet_t : the {arch reg, phys reg} pair written into the architectural map.
//   - retire_state_e : retire sequencing states.
package rob_retire_pkg;

  localparam int N               = 3;
  localparam int ROB_SZ          = 32;
  localparam int PHYS_REG_SZ     = 64;
  localparam int ARCH_REG_SZ     = 32;

  localparam int ROB_SZ_BITS     = $clog2(ROB_SZ);
  localparam int PREG_BITS       = $clog2(PHYS_REG_SZ);
  localparam int AREG_BITS       = $clog2(ARCH_REG_SZ);
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);

  typedef logic [ROB_SZ_BITS-1:0] rob_idx_t;
  typedef logic [PREG_BITS-1:0]   preg_t;
  typedef logic [AREG_BITS-1:0]   areg_t;

  typedef struct packed {
    areg_t arch_dest;
    preg_t t;
    preg_t t_old;
    logic  is_branch;
    logic  mispredict;
    logic  halt;
  } rob_packet_t;

  typedef struct packed {
    areg_t arch_reg;
    preg_t t;
  } amt_packet_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } retire_state_e;

endpackage

// File: rtl/retire_complete_list.sv
// Completion bit vector, one bit per ROB entry.
//   clock, reset     : clock and asynchronous active-low reset.
//   set_valid/set_idx: N CDB completion ports; the bit is set on the edge.
//   clr_valid/clr_idx: N retire ports; the bit is cleared on the edge.
//   clear_all        : clears the whole vector (flush).
//   complete         : current completion bits.
// Priority on one index: clear_all > retire clear > CDB set.
module retire_complete_list
  import rob_retire_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic     [N-1:0]      set_valid,
  input  rob_idx_t [N-1:0]      set_idx,
  input  logic     [N-1:0]      clr_valid,
  input  rob_idx_t [N-1:0]      clr_idx,
  input  logic                  clear_all,
  output logic     [ROB_SZ-1:0] complete
);

  logic [ROB_SZ-1:0] complete_next;

  // Sets are applied first so that a retire clear on the same index wins;
  // that index is being reallocated and any set there is stale.
  always_comb begin
    complete_next = complete;
    for (int i = 0; i < N; i++) begin
      if (set_valid[i]) complete_next[set_idx[i]] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (clr_valid[i]) complete_next[clr_idx[i]] = 1'b0;
    end
    if (clear_all) complete_next = '0;
  end

  // NOTE: this vector is control state, not a data array: a stale bit after
  // reset would retire an entry that never executed, so it must be reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) complete <= '0;
    else        complete <= complete_next;
  end

endmodule

// File: rtl/rob_retire.sv
// Retire stage at the consumer end of the ROB head interface.
//   clock, reset      : clock and asynchronous active-low reset.
//   rob_outputs       : N oldest ROB entries, oldest first.
//   rob_outputs_valid : how many of rob_outputs hold real entries.
//   rob_head          : ROB index of rob_outputs[0].
//   cdb_valid/_rob_idx: N completion broadcasts.
//   num_retiring      : entries the ROB pops this cycle (combinational).
//   free_valid/reg    : old physical register released per lane.
//   amt_we/packet     : architectural map update per lane.
//   flush             : one-cycle pulse after a mispredicted branch retires.
//   halted            : sticky after a halt retires.
//   retired_count     : running count of committed instructions (wraps).
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  rob_packet_t [N-1:0]            rob_outputs,
  input  logic        [NUM_SCALAR_BITS-1:0] rob_outputs_valid,
  input  rob_idx_t                       rob_head,
  input  logic        [N-1:0]            cdb_valid,
  input  rob_idx_t    [N-1:0]            cdb_rob_idx,
  output logic        [NUM_SCALAR_BITS-1:0] num_retiring,
  output logic        [N-1:0]            free_valid,
  output preg_t       [N-1:0]            free_reg,
  output logic        [N-1:0]            amt_we,
  output amt_packet_t [N-1:0]            amt_packet,
  output logic                           flush,
  output logic                           halted,
  output logic        [31:0]             retired_count
);

  retire_state_e      state;
  logic [ROB_SZ-1:0]  complete;
  rob_idx_t [N-1:0]   lane_idx;
  logic [N-1:0]       retire_mask;
  logic               take_flush;
  logic               take_halt;
  logic               scan_live;

  // CDB sets are dropped during the flush cycle; the clear-all covers them too,
  // but gating keeps the intent explicit.
  retire_complete_list u_complete (
    .clock     (clock),
    .reset     (reset),
    .set_valid (cdb_valid & {N{state != FLUSH}}),
    .set_idx   (cdb_rob_idx),
    .clr_valid (retire_mask),
    .clr_idx   (lane_idx),
    .clear_all (state == FLUSH),
    .complete  (complete)
  );

  // In-order scan: a lane retires only if every older lane retired and the
  // scan has not already stopped on a mispredict or halt. lane_idx wraps
  // naturally because it is ROB_SZ_BITS wide.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop, so no
    // path leaves a value held and no latch is inferred.
    num_retiring = '0;
    free_valid   = '0;
    free_reg     = '0;
    amt_we       = '0;
    amt_packet   = '0;
    retire_mask  = '0;
    lane_idx     = '0;
    take_flush   = 1'b0;
    take_halt    = 1'b0;
    // NOTE: scan_live is a blocking temporary: later iterations must see the
    // value written by earlier ones within the same evaluation.
    scan_live    = reset && (state == RUN);
    for (int i = 0; i < N; i++) begin
      lane_idx[i] = rob_head + rob_idx_t'(i);
      if (scan_live && (NUM_SCALAR_BITS'(i) < rob_outputs_valid) && complete[lane_idx[i]]) begin
        retire_mask[i] = 1'b1;
        num_retiring   = num_retiring + NUM_SCALAR_BITS'(1);
        // x0 has no architectural state and owns no physical register.
        if (rob_outputs[i].arch_dest != '0) begin
          free_valid[i]          = 1'b1;
          free_reg[i]            = rob_outputs[i].t_old;
          amt_we[i]              = 1'b1;
          amt_packet[i].arch_reg = rob_outputs[i].arch_dest;
          amt_packet[i].t        = rob_outputs[i].t;
        end
        if (rob_outputs[i].halt) begin
          take_halt = 1'b1;
          scan_live = 1'b0;
        end else if (rob_outputs[i].mispredict) begin
          take_flush = 1'b1;
          scan_live  = 1'b0;
        end
      end else begin
        scan_live = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RUN;
      flush         <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else begin
      retired_count <= retired_count + 32'(num_retiring);
      flush         <= 1'b0;
      case (state)
        RUN: begin
          // Halt outranks mispredict when both sit on the same entry.
          if (take_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (take_flush) begin
            state <= FLUSH;
            flush <= 1'b1;
          end
        end
        FLUSH:   state <= RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic                              clock;
  logic                              reset;
  rob_packet_t [N-1:0]               rob_outputs;
  logic        [NUM_SCALAR_BITS-1:0] rob_outputs_valid;
  rob_idx_t                          rob_head;
  logic        [N-1:0]               cdb_valid;
  rob_idx_t    [N-1:0]               cdb_rob_idx;
  logic        [NUM_SCALAR_BITS-1:0] num_retiring;
  logic        [N-1:0]               free_valid;
  preg_t       [N-1:0]               free_reg;
  logic        [N-1:0]               amt_we;
  amt_packet_t [N-1:0]               amt_packet;
  logic                              flush;
  logic                              halted;
  logic        [31:0]                retired_count;

  rob_retire dut (
    .clock             (clock),
    .reset             (reset),
    .rob_outputs       (rob_outputs),
    .rob_outputs_valid (rob_outputs_valid),
    .rob_head          (rob_head),
    .cdb_valid         (cdb_valid),
    .cdb_rob_idx       (cdb_rob_idx),
    .num_retiring      (num_retiring),
    .free_valid        (free_valid),
    .free_reg          (free_reg),
    .amt_we            (amt_we),
    .amt_packet        (amt_packet),
    .flush             (flush),
    .halted            (halted),
    .retired_count     (retired_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus plus the outputs expected in that cycle.
  // Lane fields are derived from the ROB index: arch = idx%31+1, T = idx,
  // T_old = idx+32. mis/halt/x0 lane = 3 means none.
  typedef struct {
    int         head;
    int         valid;
    logic [2:0] cdb_v;
    int         cdb0, cdb1, cdb2;
    int         mis_lane, halt_lane, x0_lane;
    int         e_num;
    logic [2:0] e_fv;
    logic [2:0] e_we;
    logic       e_flush;
    logic       e_halted;
    int         e_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int head, int valid, logic [2:0] cv, int c0, int c1, int c2,
                              int mis, int hlt, int x0, int num, logic [2:0] fv, logic [2:0] we,
                              logic fl, logic hd, int cnt);
    vec_t v;
    v.head = head; v.valid = valid; v.cdb_v = cv; v.cdb0 = c0; v.cdb1 = c1; v.cdb2 = c2;
    v.mis_lane = mis; v.halt_lane = hlt; v.x0_lane = x0;
    v.e_num = num; v.e_fv = fv; v.e_we = we; v.e_flush = fl; v.e_halted = hd; v.e_count = cnt;
    return v;
  endfunction

  function automatic int arch_of(int idx, int lane, int x0_lane);
    return (lane == x0_lane) ? 0 : (idx % 31) + 1;
  endfunction

  task automatic drive(input vec_t v);
    rob_head          = rob_idx_t'(v.head);
    rob_outputs_valid = NUM_SCALAR_BITS'(v.valid);
    cdb_valid         = v.cdb_v;
    cdb_rob_idx[0]    = rob_idx_t'(v.cdb0);
    cdb_rob_idx[1]    = rob_idx_t'(v.cdb1);
    cdb_rob_idx[2]    = rob_idx_t'(v.cdb2);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (v.head + i) % ROB_SZ;
      rob_outputs[i].arch_dest  = areg_t'(arch_of(idx, i, v.x0_lane));
      rob_outputs[i].t          = preg_t'(idx);
      rob_outputs[i].t_old      = preg_t'(idx + 32);
      rob_outputs[i].mispredict = (i == v.mis_lane);
      rob_outputs[i].is_branch  = (i == v.mis_lane);
      rob_outputs[i].halt       = (i == v.halt_lane);
    end
  endtask

  task automatic compare(input vec_t v, input int step);
    string s;
    s = $sformatf("s%0d", step);
    check({s, ".num_retiring"}, 32'(num_retiring), 32'(v.e_num));
    check({s, ".free_valid"},   32'(free_valid),   32'(v.e_fv));
    check({s, ".amt_we"},       32'(amt_we),       32'(v.e_we));
    check({s, ".flush"},        32'(flush),        32'(v.e_flush));
    check({s, ".halted"},       32'(halted),       32'(v.e_halted));
    check({s, ".retired_count"}, retired_count,    32'(v.e_count));
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (v.head + i) % ROB_SZ;
      check($sformatf("%s.free_reg%0d", s, i), 32'(free_reg[i]),
            v.e_fv[i] ? 32'(idx + 32) : 32'd0);
      check($sformatf("%s.amt_packet%0d", s, i), 32'(amt_packet[i]),
            v.e_we[i] ? ((arch_of(idx, i, v.x0_lane) << PREG_BITS) | idx) : 32'd0);
    end
  endtask

  initial begin
    vec_t idle;
    //          head vld cdb_v  c0 c1 c2 mis hlt x0 num fv      we      fl hd cnt
    vecs.push_back(mk( 0, 3, 3'b111,  0, 1, 2, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0,  0));
    vecs.push_back(mk( 0, 3, 3'b000,  0, 0, 0, 3, 3, 3, 3, 3'b111, 3'b111, 0, 0,  0));
    vecs.push_back(mk( 3, 3, 3'b101,  3, 0, 5, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0,  3));
    vecs.push_back(mk( 3, 3, 3'b000,  0, 0, 0, 3, 3, 3, 1, 3'b001, 3'b001, 0, 0,  3));
    vecs.push_back(mk( 4, 3, 3'b001,  4, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0,  4));
    vecs.push_back(mk( 4, 3, 3'b000,  0, 0, 0, 3, 3, 3, 2, 3'b011, 3'b011, 0, 0,  4));
    vecs.push_back(mk(30, 3, 3'b111, 30,31, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0,  6));
    vecs.push_back(mk(30, 3, 3'b001,  1, 0, 0, 3, 3, 3, 3, 3'b111, 3'b111, 0, 0,  6));
    vecs.push_back(mk( 1, 1, 3'b000,  0, 0, 0, 3, 3, 3, 1, 3'b001, 3'b001, 0, 0,  9));
    vecs.push_back(mk(30, 3, 3'b000,  0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 10));
    vecs.push_back(mk( 2, 3, 3'b111,  2, 3, 4, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 10));
    vecs.push_back(mk( 2, 3, 3'b000,  0, 0, 0, 3, 3, 0, 3, 3'b110, 3'b110, 0, 0, 10));
    vecs.push_back(mk( 5, 3, 3'b111,  5, 6, 7, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 13));
    vecs.push_back(mk( 5, 3, 3'b000,  0, 0, 0, 1, 3, 3, 2, 3'b011, 3'b011, 0, 0, 13));
    vecs.push_back(mk( 7, 3, 3'b001,  8, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 1, 0, 15));
    vecs.push_back(mk( 7, 2, 3'b000,  0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 15));
    vecs.push_back(mk( 8, 1, 3'b000,  0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 15));
    vecs.push_back(mk( 9, 3, 3'b111,  9,10,11, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 15));
    vecs.push_back(mk( 9, 3, 3'b000,  0, 0, 0, 0, 0, 3, 1, 3'b001, 3'b001, 0, 0, 15));
    vecs.push_back(mk(10, 3, 3'b000,  0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 1, 16));
    vecs.push_back(mk(10, 3, 3'b000,  0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 1, 16));

    // Reset state, with a full ROB head presented.
    reset = 1'b0;
    drive(vecs[1]);
    #1;
    check("reset.num_retiring",  32'(num_retiring), 32'd0);
    check("reset.flush",         32'(flush),         32'd0);
    check("reset.halted",        32'(halted),        32'd0);
    check("reset.retired_count", retired_count,      32'd0);

    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k]);
      #1;
      compare(vecs[k], k);
      @(negedge clock);
    end

    // Asynchronous reset in the middle of HALTED, away from any edge.
    #2;
    reset = 1'b0;
    #1;
    check("midreset.halted",        32'(halted),       32'd0);
    check("midreset.retired_count", retired_count,     32'd0);
    check("midreset.num_retiring",  32'(num_retiring), 32'd0);
    check("midreset.free_valid",    32'(free_valid),   32'd0);

    @(negedge clock);
    reset = 1'b1;
    idle = mk(10, 3, 3'b001, 10, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 0);
    drive(idle);
    #1;
    check("postreset.num_retiring", 32'(num_retiring), 32'd0);

    // Empty ROB with a completed head entry: nothing retires.
    @(negedge clock);
    idle = mk(10, 0, 3'b000, 0, 0, 0, 3, 3, 3, 0, 3'b000, 3'b000, 0, 0, 0);
    drive(idle);
    #1;
    check("empty.num_retiring", 32'(num_retiring), 32'd0);
    check("empty.free_valid",   32'(free_valid),   32'd0);
    check("empty.amt_we",       32'(amt_we),       32'd0);

    @(negedge clock);
    idle = mk(10, 1, 3'b000, 0, 0, 0, 3, 3, 3, 1, 3'b001, 3'b001, 0, 0, 0);
    drive(idle);
    #1;
    compare(idle, 100);

    @(negedge clock);
    check("final.retired_count", retired_count, 32'd1);
    check("final.halted",        32'(halted),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
